lfsr_checker: RTL and testbench

- Receive-side companion to the team's 8-bit Fibonacci LFSR pattern generator.
- Accepts the generator's parallel state word stream, self-synchronises to it, and then checks every following word against a local prediction.
- Reports lock status, per-word error pulses and a saturating error count.
- Sits at the sink end of PRBS datapath self-tests.

---
 rtl/lfsr_checker.sv | 151 +++++++++++++++
 tb/tb_lfsr_checker.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_checker.sv
// Sink-side PRBS checker: self-synchronises to an 8-bit Fibonacci LFSR word stream, then flags and counts mismatches.
// All outputs registered (1-cycle latency from the sampling edge); no backpressure, idle when in_valid=0.
module lfsr_checker #(
    parameter int             W        = 8,
    parameter logic [W-1:0]   TAPS     = 8'h1D,
    parameter int             LOCK_CNT = 4,
    parameter int             LOSS_CNT = 3,
    parameter int             ERR_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [W-1:0]     in_data,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic             zero_seen
);

    localparam int MCW = $clog2(LOCK_CNT + 1);
    localparam int SCW = $clog2(LOSS_CNT + 1);

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    state_t           r_state, w_state_nxt;
    logic [W-1:0]     r_prev, w_prev_nxt;
    logic             r_have_prev, w_have_prev_nxt;
    logic [MCW-1:0]   r_match_cnt, w_match_cnt_nxt;
    logic [SCW-1:0]   r_miss_cnt, w_miss_cnt_nxt;
    logic             r_locked;
    logic             r_err_pulse, w_err_pulse_nxt;
    logic [ERR_W-1:0] r_err_count, w_err_count_nxt;
    logic             r_zero_seen, w_zero_seen_nxt;

    logic [W-1:0]     w_pred;
    logic             w_is_zero;
    logic             w_match;
    logic [MCW-1:0]   w_match_inc;
    logic [SCW-1:0]   w_miss_inc;

    assign w_pred      = {^(r_prev & TAPS), r_prev[W-1:1]};
    assign w_is_zero   = (in_data == '0);
    // The all-zero lockup word can never count as a match, even though pred(0)==0.
    assign w_match     = r_have_prev && (in_data == w_pred) && !w_is_zero;
    assign w_match_inc = r_match_cnt + MCW'(1);
    assign w_miss_inc  = r_miss_cnt + SCW'(1);

    always_comb begin
        w_state_nxt     = r_state;
        w_prev_nxt      = r_prev;
        w_have_prev_nxt = r_have_prev;
        w_match_cnt_nxt = r_match_cnt;
        w_miss_cnt_nxt  = r_miss_cnt;
        w_err_pulse_nxt = 1'b0;
        w_err_count_nxt = r_err_count;
        w_zero_seen_nxt = r_zero_seen;

        if (in_valid) begin
            if (w_is_zero) begin
                w_zero_seen_nxt = 1'b1;
            end
            case (r_state)
                HUNT: begin
                    w_prev_nxt      = in_data;
                    w_have_prev_nxt = 1'b1;
                    if (w_match) begin
                        w_match_cnt_nxt = MCW'(1);
                        if (LOCK_CNT == 1) begin
                            w_state_nxt    = LOCKED;
                            w_miss_cnt_nxt = '0;
                        end else begin
                            w_state_nxt = VERIFY;
                        end
                    end
                end
                VERIFY: begin
                    w_prev_nxt = in_data;
                    if (w_match) begin
                        w_match_cnt_nxt = w_match_inc;
                        if (w_match_inc == MCW'(LOCK_CNT)) begin
                            w_state_nxt    = LOCKED;
                            w_miss_cnt_nxt = '0;
                        end
                    end else begin
                        w_match_cnt_nxt = '0;
                        w_state_nxt     = HUNT;
                    end
                end
                LOCKED: begin
                    // Flywheel on the prediction so one corrupted word costs exactly one error.
                    w_prev_nxt = w_pred;
                    if (w_match) begin
                        w_miss_cnt_nxt = '0;
                    end else begin
                        w_err_pulse_nxt = 1'b1;
                        if (r_err_count != '1) begin
                            w_err_count_nxt = r_err_count + ERR_W'(1);
                        end
                        if (w_miss_inc == SCW'(LOSS_CNT)) begin
                            w_state_nxt     = HUNT;
                            w_match_cnt_nxt = '0;
                            w_miss_cnt_nxt  = '0;
                            w_prev_nxt      = in_data;
                        end else begin
                            w_miss_cnt_nxt = w_miss_inc;
                        end
                    end
                end
                default: begin
                    w_state_nxt = HUNT;
                end
            endcase
        end

        if (clear) begin
            w_err_count_nxt = '0;
            w_zero_seen_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= HUNT;
            r_prev      <= '0;
            r_have_prev <= 1'b0;
            r_match_cnt <= '0;
            r_miss_cnt  <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_count <= '0;
            r_zero_seen <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_prev      <= w_prev_nxt;
            r_have_prev <= w_have_prev_nxt;
            r_match_cnt <= w_match_cnt_nxt;
            r_miss_cnt  <= w_miss_cnt_nxt;
            r_locked    <= (w_state_nxt == LOCKED);
            r_err_pulse <= w_err_pulse_nxt;
            r_err_count <= w_err_count_nxt;
            r_zero_seen <= w_zero_seen_nxt;
        end
    end

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign err_count = r_err_count;
    assign zero_seen = r_zero_seen;

endmodule

// File: tb/tb_lfsr_checker.sv
// Table-driven bench for lfsr_checker: instance a uses defaults, instance b uses ERR_W=2, LOSS_CNT=8.
module tb_lfsr_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        clr_a, vld_a, lk_a, ep_a, zs_a;
    logic [7:0]  dat_a;
    logic [15:0] ec_a;
    logic        clr_b, vld_b, lk_b, ep_b, zs_b;
    logic [7:0]  dat_b;
    logic [1:0]  ec_b;

    lfsr_checker dut_a (
        .clk(clk), .reset(reset), .clear(clr_a), .in_valid(vld_a), .in_data(dat_a),
        .locked(lk_a), .err_pulse(ep_a), .err_count(ec_a), .zero_seen(zs_a)
    );

    lfsr_checker #(.ERR_W(2), .LOSS_CNT(8)) dut_b (
        .clk(clk), .reset(reset), .clear(clr_b), .in_valid(vld_b), .in_data(dat_b),
        .locked(lk_b), .err_pulse(ep_b), .err_count(ec_b), .zero_seen(zs_b)
    );

    typedef struct {
        logic        sel;
        logic        vld;
        logic [7:0]  dat;
        logic        clr;
        logic        e_lock;
        logic        e_pulse;
        logic [15:0] e_cnt;
        logic        e_zero;
        int          rep;
    } vec_t;

    vec_t sb[$];
    vec_t t1[$];
    vec_t t2[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   step     = 0;

    function automatic vec_t mk(input logic sel, input logic vld, input logic [7:0] dat,
                                input logic clr, input logic l, input logic p,
                                input logic [15:0] c, input logic z, input int rep);
        vec_t v;
        v.sel = sel; v.vld = vld; v.dat = dat; v.clr = clr;
        v.e_lock = l; v.e_pulse = p; v.e_cnt = c; v.e_zero = z; v.rep = rep;
        return v;
    endfunction

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s step %0d: got %0h, expected %0h", name, step, act, exp);
        end
    endtask

    task automatic check_out();
        vec_t        e;
        logic        l, p, z;
        logic [15:0] c;
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_empty step %0d", step);
            return;
        end
        e = sb.pop_front();
        if (e.sel) begin
            l = lk_b; p = ep_b; z = zs_b; c = {14'd0, ec_b};
        end else begin
            l = lk_a; p = ep_a; z = zs_a; c = ec_a;
        end
        cmp("locked",    {15'd0, l}, {15'd0, e.e_lock});
        cmp("err_pulse", {15'd0, p}, {15'd0, e.e_pulse});
        cmp("err_count", c, e.e_cnt);
        cmp("zero_seen", {15'd0, z}, {15'd0, e.e_zero});
        step++;
    endtask

    task automatic idle();
        vld_a = 1'b0; clr_a = 1'b0; dat_a = 8'h00;
        vld_b = 1'b0; clr_b = 1'b0; dat_b = 8'h00;
    endtask

    // Called at posedge+1; drives one word, then checks the registered result one cycle later.
    task automatic apply(input vec_t v);
        for (int r = 0; r < v.rep; r++) begin
            idle();
            if (v.sel) begin
                vld_b = v.vld; clr_b = v.clr; dat_b = v.dat;
            end else begin
                vld_a = v.vld; clr_a = v.clr; dat_a = v.dat;
            end
            sb.push_back(v);
            @(posedge clk);
            #1;
            check_out();
        end
        idle();
    endtask

    task automatic check_all_zero();
        sb.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1));
        check_out();
        sb.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1));
        check_out();
    endtask

    // Reset asserted and released mid-cycle, away from any clock edge.
    task automatic mid_cycle_reset();
        #2 reset = 1'b1;
        #1 check_all_zero();
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle();

        // Lock, single bit error, gap, loss of lock, relock, zero word in LOCKED, clear
        t1.push_back(mk(0, 1, 8'h01, 0, 0, 0, 16'd0, 0, 1));
        t1.push_back(mk(0, 1, 8'h80, 0, 0, 0, 16'd0, 0, 1));
        t1.push_back(mk(0, 1, 8'h40, 0, 0, 0, 16'd0, 0, 1));
        t1.push_back(mk(0, 1, 8'h20, 0, 0, 0, 16'd0, 0, 1));
        t1.push_back(mk(0, 1, 8'h10, 0, 1, 0, 16'd0, 0, 1));
        t1.push_back(mk(0, 1, 8'h89, 0, 1, 1, 16'd1, 0, 1));
        t1.push_back(mk(0, 1, 8'hC4, 0, 1, 0, 16'd1, 0, 1));
        t1.push_back(mk(0, 0, 8'h00, 0, 1, 0, 16'd1, 0, 10));
        t1.push_back(mk(0, 1, 8'hE2, 0, 1, 0, 16'd1, 0, 1));
        t1.push_back(mk(0, 1, 8'h55, 0, 1, 1, 16'd2, 0, 1));
        t1.push_back(mk(0, 1, 8'h55, 0, 1, 1, 16'd3, 0, 1));
        t1.push_back(mk(0, 1, 8'h55, 0, 0, 1, 16'd4, 0, 1));
        t1.push_back(mk(0, 1, 8'h01, 0, 0, 0, 16'd4, 0, 1));
        t1.push_back(mk(0, 1, 8'h80, 0, 0, 0, 16'd4, 0, 1));
        t1.push_back(mk(0, 1, 8'h40, 0, 0, 0, 16'd4, 0, 1));
        t1.push_back(mk(0, 1, 8'h20, 0, 0, 0, 16'd4, 0, 1));
        t1.push_back(mk(0, 1, 8'h10, 0, 1, 0, 16'd4, 0, 1));
        t1.push_back(mk(0, 1, 8'h00, 0, 1, 1, 16'd5, 1, 1));
        t1.push_back(mk(0, 1, 8'hC4, 0, 1, 0, 16'd5, 1, 1));
        t1.push_back(mk(0, 0, 8'h00, 1, 1, 0, 16'd0, 0, 1));
        t1.push_back(mk(0, 1, 8'h33, 1, 1, 1, 16'd0, 0, 1));
        t1.push_back(mk(0, 1, 8'h71, 0, 1, 0, 16'd0, 0, 1));
        t1.push_back(mk(0, 1, 8'h00, 0, 1, 1, 16'd1, 1, 1));

        // Zero words after reset on a; saturation and clear-priority on b
        t2.push_back(mk(0, 1, 8'h00, 0, 0, 0, 16'd0, 1, 4));
        t2.push_back(mk(0, 0, 8'h00, 1, 0, 0, 16'd0, 0, 1));
        t2.push_back(mk(0, 1, 8'h00, 1, 0, 0, 16'd0, 0, 1));
        t2.push_back(mk(0, 1, 8'h00, 0, 0, 0, 16'd0, 1, 1));
        t2.push_back(mk(1, 1, 8'h01, 0, 0, 0, 16'd0, 0, 1));
        t2.push_back(mk(1, 1, 8'h80, 0, 0, 0, 16'd0, 0, 1));
        t2.push_back(mk(1, 1, 8'h40, 0, 0, 0, 16'd0, 0, 1));
        t2.push_back(mk(1, 1, 8'h20, 0, 0, 0, 16'd0, 0, 1));
        t2.push_back(mk(1, 1, 8'h10, 0, 1, 0, 16'd0, 0, 1));
        t2.push_back(mk(1, 1, 8'hFF, 0, 1, 1, 16'd1, 0, 1));
        t2.push_back(mk(1, 1, 8'hFF, 0, 1, 1, 16'd2, 0, 1));
        t2.push_back(mk(1, 1, 8'hFF, 0, 1, 1, 16'd3, 0, 3));
        t2.push_back(mk(1, 1, 8'hFF, 1, 1, 1, 16'd0, 0, 1));
        t2.push_back(mk(1, 1, 8'h8E, 0, 1, 0, 16'd0, 0, 1));

        #3;
        check_all_zero();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < t1.size(); i++) apply(t1[i]);

        // Locked with pending pulse, count and zero flag: reset must clear them before the next edge
        mid_cycle_reset();

        // Reach VERIFY, reset, then confirm the old history is gone (needs seed + 4 matches)
        apply(mk(0, 1, 8'h01, 0, 0, 0, 16'd0, 0, 1));
        apply(mk(0, 1, 8'h80, 0, 0, 0, 16'd0, 0, 1));
        apply(mk(0, 1, 8'h40, 0, 0, 0, 16'd0, 0, 1));
        mid_cycle_reset();
        apply(mk(0, 1, 8'h20, 0, 0, 0, 16'd0, 0, 1));
        apply(mk(0, 1, 8'h10, 0, 0, 0, 16'd0, 0, 1));
        apply(mk(0, 1, 8'h88, 0, 0, 0, 16'd0, 0, 1));
        apply(mk(0, 1, 8'hC4, 0, 0, 0, 16'd0, 0, 1));
        apply(mk(0, 1, 8'hE2, 0, 1, 0, 16'd0, 0, 1));

        mid_cycle_reset();
        for (int i = 0; i < t2.size(); i++) apply(t2[i]);

        if (sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_leftover: got %0d entries, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
